// File: rtl/difftest_intreg_sched.sv
// difftest_intreg_sched
//   Round-robin snapshot scheduler for the difftest integer register file.
//   A granted core has its NREG integer registers streamed out, one beat per
//   accepted cycle, through a single-entry registered output slot.
//
// Ports
//   clock, reset_n           : rising-edge clock, synchronous active-low reset
//   enable                   : global enable; gates new grants only
//   io_req_valid/io_req_ready: per-core snapshot request / one-hot grant
//   io_coreid_0/1            : core IDs stamped onto each beat
//   io_rf_sel/addr/rdata     : combinational register-file read port
//   io_out_*                 : beat stream (valid/ready, data, idx, coreid, last)
//   io_busy                  : high while a snapshot is streaming
//   io_snap_cnt              : completed snapshots, wraps at 16 bits
module difftest_intreg_sched #(
  parameter int NCORE = 2,
  parameter int NREG  = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  io_req_valid,
  output logic [1:0]  io_req_ready,
  input  logic [7:0]  io_coreid_0,
  input  logic [7:0]  io_coreid_1,
  output logic        io_rf_sel,
  output logic [4:0]  io_rf_addr,
  input  logic [63:0] io_rf_rdata,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [63:0] io_out_data,
  output logic [4:0]  io_out_idx,
  output logic [7:0]  io_out_coreid,
  output logic        io_out_last,
  output logic        io_busy,
  output logic [15:0] io_snap_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_n;
  logic [NCORE-1:0] grant;
  logic             grant_core;
  logic             prio;        // core that wins when both request
  logic             core_q;      // core being streamed
  logic [5:0]       rp;          // next register to load; NREG means exhausted
  logic [15:0]      snap_cnt_q;
  logic             take;
  logic             load;

  assign take = io_out_valid && io_out_ready;
  assign load = (state == STREAM) && (rp != 6'(NREG)) && (!io_out_valid || take);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    grant      = '0;
    grant_core = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n && enable && (|io_req_valid)) begin
          grant_core        = !(io_req_valid[0] && (!io_req_valid[1] || !prio));
          grant[grant_core] = 1'b1;
          state_n           = STREAM;
        end
      end
      STREAM: begin
        if (take && io_out_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The idx-0 beat is always zero (x0), so it is loaded straight into the
  // slot on the grant edge; streaming from the register file starts at rp=1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio          <= 1'b0;
      core_q        <= 1'b0;
      rp            <= '0;
      snap_cnt_q    <= '0;
      io_out_valid  <= 1'b0;
      io_out_data   <= '0;
      io_out_idx    <= '0;
      io_out_coreid <= '0;
      io_out_last   <= 1'b0;
    end else if (state == IDLE) begin
      if (|grant) begin
        core_q        <= grant_core;
        prio          <= !grant_core;
        rp            <= 6'd1;
        io_out_valid  <= 1'b1;
        io_out_data   <= '0;
        io_out_idx    <= '0;
        io_out_coreid <= grant_core ? io_coreid_1 : io_coreid_0;
        io_out_last   <= (NREG == 1);
      end
    end else begin
      if (load) begin
        io_out_valid <= 1'b1;
        io_out_data  <= io_rf_rdata;
        io_out_idx   <= rp[4:0];
        io_out_last  <= (rp == 6'(NREG - 1));
        rp           <= rp + 6'd1;
      end else if (take) begin
        io_out_valid <= 1'b0;
      end
      if (take && io_out_last) begin
        snap_cnt_q <= snap_cnt_q + 16'd1;
        rp         <= '0;
      end
    end
  end

  assign io_req_ready = grant;
  assign io_busy      = (state == STREAM);
  assign io_rf_sel    = (state == STREAM) && core_q;
  assign io_rf_addr   = (state == STREAM) ? rp[4:0] : '0;
  assign io_snap_cnt  = snap_cnt_q;

endmodule

// File: tb/tb_difftest_intreg_sched.sv
module tb_difftest_intreg_sched;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  io_req_valid = '0;
  logic [1:0]  io_req_ready;
  logic [7:0]  io_coreid_0 = 8'hA5;
  logic [7:0]  io_coreid_1 = 8'h3C;
  logic        io_rf_sel;
  logic [4:0]  io_rf_addr;
  logic [63:0] io_rf_rdata;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [63:0] io_out_data;
  logic [4:0]  io_out_idx;
  logic [7:0]  io_out_coreid;
  logic        io_out_last;
  logic        io_busy;
  logic [15:0] io_snap_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  difftest_intreg_sched #(.NCORE(2), .NREG(32)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_coreid_0(io_coreid_0), .io_coreid_1(io_coreid_1),
    .io_rf_sel(io_rf_sel), .io_rf_addr(io_rf_addr), .io_rf_rdata(io_rf_rdata),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_data(io_out_data), .io_out_idx(io_out_idx),
    .io_out_coreid(io_out_coreid), .io_out_last(io_out_last),
    .io_busy(io_busy), .io_snap_cnt(io_snap_cnt)
  );

  always #5 clock = ~clock;

  // Register file model: core 0 holds 0x1000+addr, core 1 holds 0x2000+addr.
  assign io_rf_rdata = (io_rf_sel ? 64'h2000 : 64'h1000) + 64'(io_rf_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] exp_data(input logic c, input int i);
    if (i == 0) return 64'h0;
    return (c ? 64'h2000 : 64'h1000) + 64'(i);
  endfunction

  // Called in IDLE with requests already driven; checks the grant and takes it.
  task automatic take_grant(input logic [1:0] exp_ready);
    #1;
    check("req_ready", 64'(io_req_ready), 64'(exp_ready));
    check("busy_idle", 64'(io_busy), 64'd0);
    check("rf_addr_idle", 64'(io_rf_addr), 64'd0);
    check("rf_sel_idle", 64'(io_rf_sel), 64'd0);
    tick();
  endtask

  // Consumes one full snapshot starting right after the grant edge.
  task automatic stream(input logic csel, input logic [7:0] cid,
                        input int stall_at, input int stall_len, input bit drop_en);
    int e = 0;
    int stalled = 0;
    int cycles = 0;
    while (e < 32 && cycles < 300) begin
      if (drop_en && e == 5) enable = 1'b0;
      check("ready_stream", 64'(io_req_ready), 64'd0);
      if (io_out_valid) begin
        check("idx", 64'(io_out_idx), 64'(e));
        check("data", io_out_data, exp_data(csel, e));
        check("coreid", 64'(io_out_coreid), 64'(cid));
        check("last", 64'(io_out_last), 64'(e == 31));
        check("busy", 64'(io_busy), 64'd1);
        if (e == stall_at && stalled < stall_len) begin
          io_out_ready = 1'b0;
          stalled++;
        end else begin
          io_out_ready = 1'b1;
          e++;
        end
      end else begin
        check("valid_gap", 64'(io_out_valid), 64'd1);
      end
      tick();
      cycles++;
    end
    io_out_ready = 1'b1;
    check("beats", 64'(e), 64'd32);
    check("cycles", 64'(cycles), 64'(32 + stall_len));
    check("busy_done", 64'(io_busy), 64'd0);
    check("valid_done", 64'(io_out_valid), 64'd0);
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted.
    enable = 1'b1;
    io_req_valid = 2'b11;
    tick(); tick();
    check("rst_ready", 64'(io_req_ready), 64'd0);
    check("rst_valid", 64'(io_out_valid), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_snap", 64'(io_snap_cnt), 64'd0);
    check("rst_data", io_out_data, 64'd0);
    check("rst_idx", 64'(io_out_idx), 64'd0);
    check("rst_coreid", 64'(io_out_coreid), 64'd0);
    check("rst_last", 64'(io_out_last), 64'd0);
    io_req_valid = 2'b00;
    reset_n = 1'b1;
    tick();

    // Single request from core 0.
    io_req_valid = 2'b01;
    take_grant(2'b01);
    io_req_valid = 2'b00;
    stream(1'b0, 8'hA5, -1, 0, 1'b0);
    check("snap_single", 64'(io_snap_cnt), 64'd1);

    // Contention from a fresh reset: 0, 1, 0 back to back.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    io_req_valid = 2'b11;
    take_grant(2'b01);
    stream(1'b0, 8'hA5, -1, 0, 1'b0);
    take_grant(2'b10);
    stream(1'b1, 8'h3C, -1, 0, 1'b0);
    take_grant(2'b01);
    stream(1'b0, 8'hA5, -1, 0, 1'b0);
    io_req_valid = 2'b00;
    check("snap_contend", 64'(io_snap_cnt), 64'd3);

    // Backpressure at idx 7 for 5 cycles on core 1.
    io_req_valid = 2'b10;
    take_grant(2'b10);
    io_req_valid = 2'b00;
    stream(1'b1, 8'h3C, 7, 5, 1'b0);
    check("snap_bp", 64'(io_snap_cnt), 64'd4);

    // Enable low blocks grants; dropping it mid-stream does not abort.
    enable = 1'b0;
    io_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_off_ready", 64'(io_req_ready), 64'd0);
      check("en_off_busy", 64'(io_busy), 64'd0);
      tick();
    end
    enable = 1'b1;
    take_grant(2'b10);
    io_req_valid = 2'b00;
    stream(1'b1, 8'h3C, -1, 0, 1'b1);
    enable = 1'b1;
    check("snap_en", 64'(io_snap_cnt), 64'd5);

    // Reset at idx 12 drops the snapshot; a new request restarts at idx 0.
    io_req_valid = 2'b01;
    take_grant(2'b01);
    io_req_valid = 2'b00;
    for (int i = 0; i < 12; i++) tick();
    check("abort_idx", 64'(io_out_idx), 64'd12);
    reset_n = 1'b0;
    tick();
    check("abort_valid", 64'(io_out_valid), 64'd0);
    check("abort_busy", 64'(io_busy), 64'd0);
    check("abort_snap", 64'(io_snap_cnt), 64'd0);
    reset_n = 1'b1;
    io_req_valid = 2'b01;
    take_grant(2'b01);
    io_req_valid = 2'b00;
    stream(1'b0, 8'hA5, -1, 0, 1'b0);
    check("snap_restart", 64'(io_snap_cnt), 64'd1);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.snap_cnt_q = 16'hFFFF;
    #1;
    release dut.snap_cnt_q;
    tick();
    check("snap_preload", 64'(io_snap_cnt), 64'hFFFF);
    io_req_valid = 2'b10;
    take_grant(2'b10);
    io_req_valid = 2'b00;
    stream(1'b1, 8'h3C, -1, 0, 1'b0);
    check("snap_wrap", 64'(io_snap_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
